// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter with long-latency pending scoreboard.
// Two writeback sources share one write port under round-robin; port 1
// (mul/div) results retire pending bits so decode can stall on RAW hazards.
module rf_write_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              sb_set,
   input  logic [ADDR_W-1:0] sb_set_addr,
   input  logic [ADDR_W-1:0] chk_addr1,
   input  logic [ADDR_W-1:0] chk_addr2,
   output logic              busy1,
   output logic              busy2,
   output logic              stall,
   output logic              any_pending,
   output logic [ADDR_W-1:0] write_address,
   output logic [DATA_W-1:0] write_data,
   output logic              CTRL_RegWrite
);

   localparam int DEPTH = 1 << ADDR_W;

   logic             last_grant;  // index of the most recent winner
   logic             wsrc;        // port that produced the registered write
   logic [DEPTH-1:0] pending;
   logic [DEPTH-1:0] pending_nxt;
   logic             grant0;
   logic             grant1;
   logic             retire1;

   // Round-robin: on contention the port that did not win last time goes.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_grant);
      grant1 = req1_valid & (~req0_valid | ~last_grant);
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Register the winning write; $zero is accepted but never enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_address <= '0;
         write_data    <= '0;
         CTRL_RegWrite <= 1'b0;
         wsrc          <= 1'b0;
         last_grant    <= 1'b1;
      end else if (grant0) begin
         write_address <= req0_addr;
         write_data    <= req0_data;
         CTRL_RegWrite <= |req0_addr;
         wsrc          <= 1'b0;
         last_grant    <= 1'b0;
      end else if (grant1) begin
         write_address <= req1_addr;
         write_data    <= req1_data;
         CTRL_RegWrite <= |req1_addr;
         wsrc          <= 1'b1;
         last_grant    <= 1'b1;
      end else begin
         CTRL_RegWrite <= 1'b0;
      end
   end

   // A port-1 write clears its pending bit only as it lands in the file.
   assign retire1 = CTRL_RegWrite & wsrc;

   // Next scoreboard: clear first so a same-edge set wins; entry 0 never pends.
   always_comb begin
      pending_nxt = pending;
      if (retire1) pending_nxt[write_address] = 1'b0;
      if (sb_set)  pending_nxt[sb_set_addr]   = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Scoreboard state; lost on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= pending_nxt;
   end

   // Hazard query for the two decode source operands.
   always_comb begin
      busy1       = pending[chk_addr1];
      busy2       = pending[chk_addr2];
      stall       = busy1 | busy2;
      any_pending = |pending;
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a cycle-by-cycle vector table plus
// hand sequences for reset behaviour and round-robin from reset.
module tb_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0, sb_set = 1'b0;
   logic [4:0]  req0_addr = '0, req1_addr = '0, sb_set_addr = '0;
   logic [4:0]  chk_addr1 = '0, chk_addr2 = '0;
   logic [31:0] req0_data = '0, req1_data = '0;
   logic        req0_ready, req1_ready, busy1, busy2, stall, any_pending;
   logic [4:0]  write_address;
   logic [31:0] write_data;
   logic        CTRL_RegWrite;

   int tests = 0;
   int fails = 0;

   rf_write_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
      .req1_ready(req1_ready),
      .sb_set(sb_set), .sb_set_addr(sb_set_addr),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
      .busy1(busy1), .busy2(busy2), .stall(stall), .any_pending(any_pending),
      .write_address(write_address), .write_data(write_data),
      .CTRL_RegWrite(CTRL_RegWrite)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rdy0, rdy1, we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        b1, b2, st, any;
   } out_t;

   typedef struct {
      logic        r0v;
      logic [4:0]  r0a;
      logic [31:0] r0d;
      logic        r1v;
      logic [4:0]  r1a;
      logic [31:0] r1d;
      logic        sbs;
      logic [4:0]  sba, c1, c2;
      out_t        exp;
   } vec_t;

   localparam int NV = 18;
   vec_t tbl[NV];

   function automatic vec_t mk(
      logic r0v, logic [4:0] r0a, logic [31:0] r0d,
      logic r1v, logic [4:0] r1a, logic [31:0] r1d,
      logic sbs, logic [4:0] sba, logic [4:0] c1, logic [4:0] c2,
      logic rdy0, logic rdy1, logic we, logic [4:0] wa, logic [31:0] wd,
      logic b1, logic b2, logic st, logic any);
      vec_t v;
      v.r0v = r0v; v.r0a = r0a; v.r0d = r0d;
      v.r1v = r1v; v.r1a = r1a; v.r1d = r1d;
      v.sbs = sbs; v.sba = sba; v.c1 = c1; v.c2 = c2;
      v.exp = {rdy0, rdy1, we, wa, wd, b1, b2, st, any};
      return v;
   endfunction

   function automatic out_t sample();
      return {req0_ready, req1_ready, CTRL_RegWrite, write_address, write_data,
              busy1, busy2, stall, any_pending};
   endfunction

   task automatic apply(input vec_t v);
      req0_valid = v.r0v; req0_addr = v.r0a; req0_data = v.r0d;
      req1_valid = v.r1v; req1_addr = v.r1a; req1_data = v.r1d;
      sb_set = v.sbs; sb_set_addr = v.sba;
      chk_addr1 = v.c1; chk_addr2 = v.c2;
   endtask

   task automatic idle();
      req0_valid = 1'b0; req1_valid = 1'b0; sb_set = 1'b0;
   endtask

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      // rows: inputs ... | rdy0 rdy1 we wa wd b1 b2 stall any
      tbl[0]  = mk(0,0,0,          0,0,0,          0,0, 9,9, 0,0,0,0,0,0,0,0,0);
      tbl[1]  = mk(1,5,32'hDEADBEEF,0,0,0,         0,0, 9,9, 1,0,0,0,0,0,0,0,0);
      tbl[2]  = mk(0,0,0,          0,0,0,          0,0, 9,9, 0,0,1,5,32'hDEADBEEF,0,0,0,0);
      tbl[3]  = mk(1,3,32'h11,     1,4,32'h22,     0,0, 9,9, 0,1,0,5,32'hDEADBEEF,0,0,0,0);
      tbl[4]  = mk(1,3,32'h11,     0,0,0,          0,0, 9,9, 1,0,1,4,32'h22,0,0,0,0);
      tbl[5]  = mk(0,0,0,          1,0,32'hFFFFFFFF,1,0, 9,9, 0,1,1,3,32'h11,0,0,0,0);
      tbl[6]  = mk(0,0,0,          0,0,0,          1,9, 9,2, 0,0,0,0,32'hFFFFFFFF,0,0,0,0);
      tbl[7]  = mk(0,0,0,          0,0,0,          0,0, 9,2, 0,0,0,0,32'hFFFFFFFF,1,0,1,1);
      tbl[8]  = mk(1,9,32'h55,     0,0,0,          0,0, 9,2, 1,0,0,0,32'hFFFFFFFF,1,0,1,1);
      tbl[9]  = mk(0,0,0,          0,0,0,          0,0, 9,2, 0,0,1,9,32'h55,1,0,1,1);
      tbl[10] = mk(0,0,0,          1,9,32'h1234,   0,0, 9,2, 0,1,0,9,32'h55,1,0,1,1);
      tbl[11] = mk(0,0,0,          0,0,0,          0,0, 9,2, 0,0,1,9,32'h1234,1,0,1,1);
      tbl[12] = mk(0,0,0,          0,0,0,          0,0, 9,2, 0,0,0,9,32'h1234,0,0,0,0);
      tbl[13] = mk(0,0,0,          0,0,0,          1,7, 7,9, 0,0,0,9,32'h1234,0,0,0,0);
      tbl[14] = mk(0,0,0,          1,7,32'h77,     0,0, 7,9, 0,1,0,9,32'h1234,1,0,1,1);
      tbl[15] = mk(0,0,0,          0,0,0,          1,7, 7,9, 0,0,1,7,32'h77,1,0,1,1);
      tbl[16] = mk(0,0,0,          0,0,0,          0,0, 7,9, 0,0,0,7,32'h77,1,0,1,1);
      tbl[17] = mk(0,0,0,          0,0,0,          0,0, 0,7, 0,0,0,7,32'h77,0,1,1,1);

      // Reset held with random inputs: registered outputs and scoreboard stay clear.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req0_valid = 1'($urandom); req0_addr = 5'($urandom); req0_data = $urandom;
         req1_valid = 1'($urandom); req1_addr = 5'($urandom); req1_data = $urandom;
         sb_set = 1'($urandom); sb_set_addr = 5'($urandom);
         chk_addr1 = 5'($urandom); chk_addr2 = 5'($urandom);
         #2;
         check($sformatf("rst_hold%0d", i),
               64'({CTRL_RegWrite, write_address, write_data, busy1, busy2, stall, any_pending}),
               64'(0));
      end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      #2 check("rst_release", 64'(sample()), 64'(0));

      // Table-driven walk: write latency, RR, $zero, scoreboard life, collision.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         apply(tbl[i]);
         #2 check($sformatf("vec%0d", i), 64'(sample()), 64'(tbl[i].exp));
      end

      // Mid-operation reset drops the in-flight write and pending bits.
      @(negedge clk);
      idle();
      sb_set = 1'b1; sb_set_addr = 5'd12; chk_addr1 = 5'd12; chk_addr2 = 5'd0;
      @(negedge clk);
      sb_set = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'hCAFE;
      #2 check("mid_busy_before", 64'({busy1, any_pending}), 64'(2'b11));
      @(negedge clk);
      idle();
      #2 check("mid_write_before", 64'({CTRL_RegWrite, write_address}), 64'({1'b1, 5'd6}));
      rst_n = 1'b0;
      #1 check("mid_rst_async",
               64'({CTRL_RegWrite, write_address, write_data, busy1, any_pending}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Contention held from reset: port 0 wins first, then port 1.
      @(negedge clk);
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
      req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
      @(negedge clk);
      rst_n = 1'b1;
      #2 check("rr_first", 64'({req0_ready, req1_ready, CTRL_RegWrite}), 64'(3'b100));
      @(negedge clk);
      #2 check("rr_second", 64'({req0_ready, req1_ready, CTRL_RegWrite, write_address, write_data}),
               64'({3'b011, 5'd3, 32'h11}));
      @(negedge clk);
      idle();
      #2 check("rr_write2", 64'({CTRL_RegWrite, write_address, write_data}),
               64'({1'b1, 5'd4, 32'h22}));
      @(negedge clk);
      #2 check("rr_done", 64'({req0_ready, req1_ready, CTRL_RegWrite}), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
